bp_update_scheduler: RTL and testbench
======================================

// Module: bp_update_scheduler
// PURPOSE
//  Serialises branch-resolution updates into the predictor's single-write-port tables (BHT/PHT/CPHT/BTB).
//  Two resolution slots from ID/EX feed a small in-order queue, which drains one write per cycle.
//  Also runs the table-clear sweep after reset and on a clear request.
//  Produces a registered GHR-recovery pulse on misprediction.
//  Sits between the decode/execute branch resolution logic and the branch_prediction top.
// PARAMETERS
//  DEPTH    4   update queue entries; power of two, >=2
//  IDX_W    8   table index width; the clear sweep covers 2**IDX_W entries
//  TAR_W    32  branch target / pc width
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high reset
//  stall          in   1      predictor frozen; no table write issued
//  clr_req        in   1      request full table clear (one-cycle pulse)
//  upd0_valid     in   1      slot0 resolved branch
//  upd0_pc        in   TAR_W  slot0 branch pc
//  upd0_taken     in   1      slot0 actual direction
//  upd0_target    in   TAR_W  slot0 actual target
//  upd0_type      in   2      slot0 branch type (BTYPE_*)
//  upd0_mispred   in   1      slot0 prediction was wrong
//  upd1_*         in   -      same fields for slot1 (younger than slot0)
//  upd_ready      out  1      queue can accept two entries this cycle
//  tbl_we         out  1      table write strobe
//  tbl_clr        out  1      with tbl_we: write reset value at tbl_idx
//  tbl_idx        out  IDX_W  clear-sweep index (valid when tbl_clr=1)
//  tbl_pc/_taken/_target/_type  out  -  update payload (valid when tbl_we & !tbl_clr)
//  recov_valid    out  1      one-cycle GHR restore request
//  recov_taken    out  1      actual direction to splice into the restored GHR
//  busy           out  1      FSM in CLEAR or queue non-empty
// BEHAVIOUR
//  Reset values: all outputs 0; queue empty; FSM=CLEAR with idx=0.
//  FSM states and transitions:
//   CLEAR: tbl_we=1, tbl_clr=1, tbl_idx=idx; idx++ each cycle.
//    idx advances even when stall=1, because the clear must complete.
//    Leave to RUN after idx=2**IDX_W-1; total sweep = 2**IDX_W cycles.
//    upd_ready=0 throughout; upd*_valid is ignored.
//   RUN: if the queue is non-empty and !stall, pop the head onto tbl_* with tbl_we=1, tbl_clr=0.
//    Outputs are combinational from the head; the pop takes effect at the clock edge.
//    clr_req -> CLEAR next cycle, queue discarded, idx=0.
//    clr_req takes priority over a same-cycle pop and push; the pop still shows on tbl_* that cycle.
//  Push rules:
//   Accept when upd_ready=1, i.e. free >= 2, where free is counted before this cycle's pop.
//   Slot0 is enqueued before slot1.
//   If upd0_valid & upd0_mispred, slot1 is wrong-path and is dropped, even if upd1_valid.
//   Pushes while upd_ready=0 are lost; the issuer must hold them off.
//  Recovery:
//   recov_valid is registered: 1 the cycle after an accepted mispredicting entry.
//   recov_taken carries that entry's upd_taken.
//   Slot0 mispred wins; slot1 mispred is used only if slot0 is not mispredicting.
//   recov_valid is independent of stall and of queue drain.
//  Counters:
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   count is log2(DEPTH)+1 bits; count_next = count + pushes - pop, where pushes is 0, 1 or 2.
//  Simultaneous push and pop on a full-minus-2 queue is legal; count stays <= DEPTH.
//  Reset during CLEAR or RUN restarts the sweep from idx=0.
// STRUCTURE
//  Shared defines header: BTYPE_* codes, branch-info field macros, DEPTH/IDX_W defaults.
//  One sub-module, bp_upd_fifo: 2-write / 1-read circular queue that exports count.
//  The FSM and recovery register live in the top.
// TESTING
//  1. Reset, IDX_W=8 -> tbl_clr=1 with idx 0..255 over 256 cycles; upd_ready=0 until cycle 256, then RUN.
//  2. RUN; slot0 pc=0x80, taken, with slot1 pc=0x90 in the same cycle
//     -> tbl_pc=0x80 next cycle, then 0x90 the cycle after; busy drops after that.
//  3. slot0 mispred=1, taken=0, plus valid slot1
//     -> slot1 is never written; recov_valid=1, recov_taken=0 exactly one cycle later.
//  4. stall=1 for 5 cycles with 2 pushes (DEPTH=4)
//     -> tbl_we=0 during the stall; upd_ready=0 once count=3; all entries drain in order after the stall.
//  5. clr_req while 3 entries are queued
//     -> head written that cycle, remaining entries discarded, 256-cycle sweep restarts.
//  6. Assert reset mid-sweep at idx=100 -> the next sweep starts at idx=0; no stale tbl_we.

Source files
------------

// File: rtl/bp_update_scheduler_pkg.sv
// rtl/bp_update_scheduler_pkg.sv - shared types and constants for the branch update scheduler
package bp_update_scheduler_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int IDX_W_DEF = 8;
  localparam int TAR_W_DEF = 32;

  localparam logic [1:0] BTYPE_COND = 2'd0;
  localparam logic [1:0] BTYPE_JAL  = 2'd1;
  localparam logic [1:0] BTYPE_JALR = 2'd2;
  localparam logic [1:0] BTYPE_RET  = 2'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - two-write / one-read circular queue exporting its occupancy
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic [1:0]    push_n_i,
  input  logic [W-1:0]  wdata0_i,
  input  logic [W-1:0]  wdata1_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_p1;

  assign wr_ptr_p1 = wr_ptr_q + PW'(1);

  // Entry storage; data needs no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_n_i != 2'd0) mem_q[wr_ptr_q] <= wdata0_i;
    if (push_n_i == 2'd2) mem_q[wr_ptr_p1] <= wdata1_i;
  end

  // Pointer and occupancy bookkeeping; a flush drops every entry at once.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_n_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + CW'(push_n_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - serialises branch updates and table clears onto one write port
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAR_W = TAR_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             clr_req_i,
  input  logic             upd0_valid_i,
  input  logic [TAR_W-1:0] upd0_pc_i,
  input  logic             upd0_taken_i,
  input  logic [TAR_W-1:0] upd0_target_i,
  input  logic [1:0]       upd0_type_i,
  input  logic             upd0_mispred_i,
  input  logic             upd1_valid_i,
  input  logic [TAR_W-1:0] upd1_pc_i,
  input  logic             upd1_taken_i,
  input  logic [TAR_W-1:0] upd1_target_i,
  input  logic [1:0]       upd1_type_i,
  input  logic             upd1_mispred_i,
  output logic             upd_ready_o,
  output logic             tbl_we_o,
  output logic             tbl_clr_o,
  output logic [IDX_W-1:0] tbl_idx_o,
  output logic [TAR_W-1:0] tbl_pc_o,
  output logic             tbl_taken_o,
  output logic [TAR_W-1:0] tbl_target_o,
  output logic [1:0]       tbl_type_o,
  output logic             recov_valid_o,
  output logic             recov_taken_o,
  output logic             busy_o
);

  localparam int EW = 2 * TAR_W + 3;
  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e     state_q;
  logic [IDX_W-1:0] idx_q;
  logic             recov_valid_q;
  logic             recov_taken_q;

  logic [CW-1:0]    count;
  logic             empty;
  logic [EW-1:0]    head;
  logic [EW-1:0]    entry0;
  logic [EW-1:0]    entry1;

  logic             in_run;
  logic             in_clear;
  logic             accept;
  logic             v0;
  logic             v1;
  logic [1:0]       push_n;
  logic             pop;
  logic             flush;
  logic             rec_v_d;
  logic             rec_t_d;
  logic             pay_en;

  assign in_run   = !reset_i && (state_q == ST_RUN);
  assign in_clear = !reset_i && (state_q == ST_CLEAR);

  // Free space is judged before this cycle's pop so the issuer sees a stable ready.
  assign upd_ready_o = in_run && (count <= CW'(DEPTH - 2));
  assign accept      = upd_ready_o && !clr_req_i;

  // A mispredicting slot0 makes slot1 wrong-path.
  assign v0 = accept && upd0_valid_i;
  assign v1 = accept && upd1_valid_i && !(upd0_valid_i && upd0_mispred_i);

  assign entry0 = {upd0_pc_i, upd0_taken_i, upd0_target_i, upd0_type_i};
  assign entry1 = {upd1_pc_i, upd1_taken_i, upd1_target_i, upd1_type_i};
  assign push_n = 2'(v0) + 2'(v1);

  assign pop   = in_run && !empty && !stall_i;
  assign flush = in_run && clr_req_i;

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush_i  (flush),
    .push_n_i (push_n),
    .wdata0_i (v0 ? entry0 : entry1),
    .wdata1_i (entry1),
    .pop_i    (pop),
    .head_o   (head),
    .count_o  (count),
    .empty_o  (empty)
  );

  assign rec_v_d = (v0 && upd0_mispred_i) || (v1 && upd1_mispred_i);
  assign rec_t_d = (v0 && upd0_mispred_i) ? upd0_taken_i : upd1_taken_i;

  // Sweep/run state machine plus the registered GHR-recovery pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_CLEAR;
      idx_q         <= '0;
      recov_valid_q <= 1'b0;
      recov_taken_q <= 1'b0;
    end else begin
      recov_valid_q <= rec_v_d;
      recov_taken_q <= rec_v_d ? rec_t_d : 1'b0;
      case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == '1) state_q <= ST_RUN;
        end
        default: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
          end
        end
      endcase
    end
  end

  assign tbl_we_o  = in_clear || pop;
  assign tbl_clr_o = in_clear;
  assign tbl_idx_o = in_clear ? idx_q : '0;

  assign pay_en       = pop;
  assign tbl_pc_o     = pay_en ? head[EW-1 -: TAR_W] : '0;
  assign tbl_taken_o  = pay_en ? head[TAR_W+2] : 1'b0;
  assign tbl_target_o = pay_en ? head[TAR_W+1 -: TAR_W] : '0;
  assign tbl_type_o   = pay_en ? head[1:0] : 2'b00;

  assign recov_valid_o = recov_valid_q;
  assign recov_taken_o = recov_taken_q;
  assign busy_o        = in_clear || (!reset_i && !empty);

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - scoreboard bench for bp_update_scheduler
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int TAR_W = 32;
  localparam int NIDX  = 1 << IDX_W;

  typedef struct {
    logic [TAR_W-1:0] pc;
    logic             taken;
    logic [TAR_W-1:0] target;
    logic [1:0]       typ;
  } upd_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, stall_i = 1'b0, clr_req_i = 1'b0;
  logic upd0_valid_i = 1'b0, upd0_taken_i = 1'b0, upd0_mispred_i = 1'b0;
  logic [TAR_W-1:0] upd0_pc_i = '0, upd0_target_i = '0;
  logic [1:0] upd0_type_i = '0;
  logic upd1_valid_i = 1'b0, upd1_taken_i = 1'b0, upd1_mispred_i = 1'b0;
  logic [TAR_W-1:0] upd1_pc_i = '0, upd1_target_i = '0;
  logic [1:0] upd1_type_i = '0;
  logic upd_ready_o, tbl_we_o, tbl_clr_o, tbl_taken_o, recov_valid_o, recov_taken_o, busy_o;
  logic [IDX_W-1:0] tbl_idx_o;
  logic [TAR_W-1:0] tbl_pc_o, tbl_target_o;
  logic [1:0] tbl_type_o;

  int errors = 0;
  int checks = 0;
  upd_t exp_q[$];

  always #5 clk = ~clk;

  bp_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAR_W(TAR_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .stall_i(stall_i), .clr_req_i(clr_req_i),
    .upd0_valid_i(upd0_valid_i), .upd0_pc_i(upd0_pc_i), .upd0_taken_i(upd0_taken_i),
    .upd0_target_i(upd0_target_i), .upd0_type_i(upd0_type_i), .upd0_mispred_i(upd0_mispred_i),
    .upd1_valid_i(upd1_valid_i), .upd1_pc_i(upd1_pc_i), .upd1_taken_i(upd1_taken_i),
    .upd1_target_i(upd1_target_i), .upd1_type_i(upd1_type_i), .upd1_mispred_i(upd1_mispred_i),
    .upd_ready_o(upd_ready_o), .tbl_we_o(tbl_we_o), .tbl_clr_o(tbl_clr_o), .tbl_idx_o(tbl_idx_o),
    .tbl_pc_o(tbl_pc_o), .tbl_taken_o(tbl_taken_o), .tbl_target_o(tbl_target_o),
    .tbl_type_o(tbl_type_o), .recov_valid_o(recov_valid_o), .recov_taken_o(recov_taken_o),
    .busy_o(busy_o)
  );

  // Scoreboard: every update write must match the oldest expected entry.
  always @(negedge clk) begin
    if (tbl_we_o === 1'b1 && tbl_clr_o === 1'b0) begin
      upd_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got pc=%h with nothing expected", tbl_pc_o);
      end else begin
        e = exp_q.pop_front();
        if ({tbl_pc_o, tbl_taken_o, tbl_target_o, tbl_type_o} !== {e.pc, e.taken, e.target, e.typ}) begin
          errors++;
          $display("FAIL write_payload: got pc=%h tk=%b tgt=%h ty=%0d want pc=%h tk=%b tgt=%h ty=%0d",
                   tbl_pc_o, tbl_taken_o, tbl_target_o, tbl_type_o, e.pc, e.taken, e.target, e.typ);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [TAR_W-1:0] pc, input logic tk,
                        input logic [TAR_W-1:0] tgt, input logic [1:0] ty, input logic mis);
    upd0_valid_i = v; upd0_pc_i = pc; upd0_taken_i = tk;
    upd0_target_i = tgt; upd0_type_i = ty; upd0_mispred_i = mis;
  endtask

  task automatic drive1(input logic v, input logic [TAR_W-1:0] pc, input logic tk,
                        input logic [TAR_W-1:0] tgt, input logic [1:0] ty, input logic mis);
    upd1_valid_i = v; upd1_pc_i = pc; upd1_taken_i = tk;
    upd1_target_i = tgt; upd1_type_i = ty; upd1_mispred_i = mis;
  endtask

  task automatic expect_upd(input logic [TAR_W-1:0] pc, input logic tk,
                            input logic [TAR_W-1:0] tgt, input logic [1:0] ty);
    upd_t e;
    e.pc = pc; e.taken = tk; e.target = tgt; e.typ = ty;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    drive0(1'b0, '0, 1'b0, '0, 2'd0, 1'b0);
    drive1(1'b0, '0, 1'b0, '0, 2'd0, 1'b0);
  endtask

  // Starts in the first CLEAR cycle (idx=0); ends at the first RUN cycle.
  task automatic run_sweep(input string name);
    for (int i = 0; i < NIDX; i++) begin
      @(negedge clk);
      checks++;
      if ({tbl_we_o, tbl_clr_o, tbl_idx_o, upd_ready_o} !== {1'b1, 1'b1, IDX_W'(i), 1'b0}) begin
        errors++;
        $display("FAIL %s_sweep[%0d]: we=%b clr=%b idx=%0d rdy=%b want we=1 clr=1 idx=%0d rdy=0",
                 name, i, tbl_we_o, tbl_clr_o, tbl_idx_o, upd_ready_o, i);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({upd_ready_o, tbl_we_o, busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL %s_run_entry: rdy=%b we=%b busy=%b want rdy=1 we=0 busy=0",
               name, upd_ready_o, tbl_we_o, busy_o);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b want pending=0 busy=0", name, exp_q.size(), busy_o);
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({upd_ready_o, tbl_we_o, tbl_clr_o, tbl_idx_o, recov_valid_o, recov_taken_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b clr=%b idx=%0d rv=%b rt=%b busy=%b want all 0",
               upd_ready_o, tbl_we_o, tbl_clr_o, tbl_idx_o, recov_valid_o, recov_taken_o, busy_o);
    end
    tick();
    reset_i = 1'b0;
    run_sweep("reset");
    tick();
  endtask

  task automatic test_pair_push();
    drive0(1'b1, 32'h80, 1'b1, 32'h100, BTYPE_COND, 1'b0);
    drive1(1'b1, 32'h90, 1'b0, 32'h94, BTYPE_JAL, 1'b0);
    expect_upd(32'h80, 1'b1, 32'h100, BTYPE_COND);
    expect_upd(32'h90, 1'b0, 32'h94, BTYPE_JAL);
    @(negedge clk);
    checks++;
    if (tbl_we_o !== 1'b0) begin
      errors++;
      $display("FAIL pair_same_cycle_we: got %b want 0", tbl_we_o);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (tbl_pc_o !== 32'h80) begin
      errors++;
      $display("FAIL pair_first_pc: got %h want 00000080", tbl_pc_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (tbl_pc_o !== 32'h90) begin
      errors++;
      $display("FAIL pair_second_pc: got %h want 00000090", tbl_pc_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pair_busy_drop: busy=%b pending=%0d want busy=0 pending=0", busy_o, exp_q.size());
    end
    tick();
  endtask

  task automatic test_recovery();
    drive0(1'b1, 32'hA0, 1'b0, 32'hA4, BTYPE_COND, 1'b1);
    drive1(1'b1, 32'hB0, 1'b1, 32'hB8, BTYPE_JALR, 1'b0);
    expect_upd(32'hA0, 1'b0, 32'hA4, BTYPE_COND);
    @(negedge clk);
    checks++;
    if (recov_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL recov_early: got %b want 0", recov_valid_o);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({recov_valid_o, recov_taken_o} !== 2'b10) begin
      errors++;
      $display("FAIL recov_slot0: valid=%b taken=%b want valid=1 taken=0", recov_valid_o, recov_taken_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (recov_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL recov_one_cycle: got %b want 0", recov_valid_o);
    end
    tick();
    wait_drain("recov_s0");
    drive0(1'b1, 32'hE0, 1'b1, 32'hE8, BTYPE_RET, 1'b0);
    drive1(1'b1, 32'hE4, 1'b1, 32'h200, BTYPE_JALR, 1'b1);
    expect_upd(32'hE0, 1'b1, 32'hE8, BTYPE_RET);
    expect_upd(32'hE4, 1'b1, 32'h200, BTYPE_JALR);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({recov_valid_o, recov_taken_o} !== 2'b11) begin
      errors++;
      $display("FAIL recov_slot1: valid=%b taken=%b want valid=1 taken=1", recov_valid_o, recov_taken_o);
    end
    tick();
    wait_drain("recov_s1");
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    drive0(1'b1, 32'hC0, 1'b1, 32'hC0C0, BTYPE_COND, 1'b0);
    drive1(1'b1, 32'hC4, 1'b0, 32'hC4C4, BTYPE_JAL, 1'b0);
    expect_upd(32'hC0, 1'b1, 32'hC0C0, BTYPE_COND);
    expect_upd(32'hC4, 1'b0, 32'hC4C4, BTYPE_JAL);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tbl_we_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_we[%0d]: got %b want 0", c, tbl_we_o);
      end
      if (c == 2) begin
        checks++;
        if (upd_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready_full: got %b want 0 at count 3", upd_ready_o);
        end
      end
      tick();
      if (c == 0) begin
        drive0(1'b1, 32'hC8, 1'b1, 32'hC8C8, BTYPE_RET, 1'b0);
        drive1(1'b0, '0, 1'b0, '0, 2'd0, 1'b0);
        expect_upd(32'hC8, 1'b1, 32'hC8C8, BTYPE_RET);
      end else begin
        idle_inputs();
      end
    end
    stall_i = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_back_to_back();
    drive0(1'b1, 32'hF0, 1'b0, 32'h1F0, BTYPE_COND, 1'b0);
    drive1(1'b1, 32'hF4, 1'b1, 32'h1F4, BTYPE_COND, 1'b0);
    expect_upd(32'hF0, 1'b0, 32'h1F0, BTYPE_COND);
    expect_upd(32'hF4, 1'b1, 32'h1F4, BTYPE_COND);
    tick();
    drive0(1'b1, 32'hF8, 1'b1, 32'h1F8, BTYPE_JAL, 1'b0);
    drive1(1'b1, 32'hFC, 1'b0, 32'h1FC, BTYPE_RET, 1'b0);
    expect_upd(32'hF8, 1'b1, 32'h1F8, BTYPE_JAL);
    expect_upd(32'hFC, 1'b0, 32'h1FC, BTYPE_RET);
    @(negedge clk);
    checks++;
    if (upd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_at2: got %b want 1", upd_ready_o);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (upd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_at3: got %b want 0", upd_ready_o);
    end
    tick();
    wait_drain("b2b");
    drive1(1'b1, 32'h110, 1'b1, 32'h114, BTYPE_JALR, 1'b0);
    expect_upd(32'h110, 1'b1, 32'h114, BTYPE_JALR);
    tick();
    idle_inputs();
    wait_drain("slot1_only");
  endtask

  task automatic test_clear_req();
    stall_i = 1'b1;
    drive0(1'b1, 32'hD0, 1'b1, 32'h1D0, BTYPE_COND, 1'b0);
    drive1(1'b1, 32'hD4, 1'b0, 32'h1D4, BTYPE_COND, 1'b0);
    expect_upd(32'hD0, 1'b1, 32'h1D0, BTYPE_COND);
    expect_upd(32'hD4, 1'b0, 32'h1D4, BTYPE_COND);
    tick();
    drive0(1'b1, 32'hD8, 1'b0, 32'h1D8, BTYPE_JAL, 1'b0);
    drive1(1'b0, '0, 1'b0, '0, 2'd0, 1'b0);
    expect_upd(32'hD8, 1'b0, 32'h1D8, BTYPE_JAL);
    tick();
    idle_inputs();
    stall_i = 1'b0;
    clr_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({tbl_we_o, tbl_clr_o, tbl_pc_o} !== {1'b1, 1'b0, 32'hD0}) begin
      errors++;
      $display("FAIL clr_head_write: we=%b clr=%b pc=%h want we=1 clr=0 pc=000000d0",
               tbl_we_o, tbl_clr_o, tbl_pc_o);
    end
    tick();
    clr_req_i = 1'b0;
    exp_q.delete();
    run_sweep("clrreq");
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    clr_req_i = 1'b1;
    drive0(1'b1, 32'h1234, 1'b1, 32'h5678, BTYPE_COND, 1'b1);
    tick();
    clr_req_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    @(negedge clk);
    checks++;
    if (tbl_idx_o !== IDX_W'(100)) begin
      errors++;
      $display("FAIL midsweep_idx: got %0d want 100", tbl_idx_o);
    end
    tick();
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({tbl_we_o, busy_o, upd_ready_o, recov_valid_o} !== 4'b0000) begin
      errors++;
      $display("FAIL midsweep_reset_outputs: we=%b busy=%b rdy=%b rv=%b want all 0",
               tbl_we_o, busy_o, upd_ready_o, recov_valid_o);
    end
    tick();
    reset_i = 1'b0;
    idle_inputs();
    run_sweep("midreset");
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checks++;
    if ({tbl_we_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL midsweep_quiet: we=%b busy=%b want 0 0", tbl_we_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_pair_push();
    test_recovery();
    test_stall();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
